// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle control unit: state encodings,
// recognised opcodes, ALUOp codes and PCSource codes.
// No ports (package).
// -----------------------------------------------------------------------------
package mc_pkg;

    // State encodings (also exposed on state_o for debug)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    // Recognised opcodes (resized to the opcode width at the point of use)
    localparam int OPC_RTYPE = 0;
    localparam int OPC_J     = 2;
    localparam int OPC_BEQ   = 4;
    localparam int OPC_ADDI  = 8;
    localparam int OPC_LW    = 35;
    localparam int OPC_SW    = 43;

    // ALU operation selects
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on the memory handshake
    function automatic logic is_mem_wait_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// -----------------------------------------------------------------------------
// mc_wait_timer
// Counts consecutive memory wait cycles and flags the cycle in which the
// count reaches TIMEOUT while the access is still waiting.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   clear   - restart the count (controller changes state)
//   waiting - current cycle is a memory wait cycle (mem_ready low)
//   expired - this wait cycle is the TIMEOUT-th consecutive one
// -----------------------------------------------------------------------------
module mc_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    // count_q holds the number of wait cycles already completed, so the
    // current cycle is number count_q+1.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        expired = waiting && (count_q == LAST_CNT);
        count_d = count_q + 8'd1;
        // An expiry restarts the access even when the state does not change
        // (timeout in FETCH), so it clears the count as well.
        if (clear || !waiting || expired) begin
            count_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of a multicycle MIPS-style datapath with memory wait
// handling and access timeout.
// Optional feature: define MULTICYCLE_CONTROL_JUMP_EN to support J (opcode 2);
// otherwise opcode 2 traps as illegal.
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   Opcode            - opcode field of the instruction register
//   mem_ready         - memory completes the current access this cycle
//   PCWrite .. ALUSrcA, ALUSrcB, ALUOp, PCSource - datapath controls
//   illegal_op        - one-cycle pulse for an unsupported opcode
//   mem_err           - one-cycle pulse on a memory access timeout
//   state_o           - current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OP_W                 = 6,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] Opcode,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            IRWrite,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            illegal_op,
    output logic            mem_err,
    output logic [3:0]      state_o
);

    logic [3:0]      state_q;
    logic [3:0]      state_d;
    logic [OP_W-1:0] opcode_q;
    logic [OP_W-1:0] opcode_d;
    logic            waiting;
    logic            expired;
    logic            timeout;

    assign waiting = is_mem_wait_state(state_q) && !mem_ready;

    mc_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_d != state_q),
        .waiting (waiting),
        .expired (expired)
    );

    // Opcode is captured in DECODE so that MEMADR picks read vs write from
    // the instruction that was decoded, not from whatever is on the bus now.
    assign opcode_d = (state_q == S_DECODE) ? Opcode : opcode_q;

    always_ff @(posedge clk) begin
        opcode_q <= opcode_d;
    end

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    timeout = 1'b1;
                end
            end
            S_DECODE: begin
                if (Opcode == OP_W'(OPC_LW) || Opcode == OP_W'(OPC_SW)) begin
                    state_d = S_MEMADR;
                end else if (Opcode == OP_W'(OPC_RTYPE)) begin
                    state_d = S_EXEC;
                end else if (Opcode == OP_W'(OPC_BEQ)) begin
                    state_d = S_BRANCH;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
                end else if (Opcode == OP_W'(OPC_J)) begin
                    state_d = S_JUMP;
`endif
                end else if (Opcode == OP_W'(OPC_ADDI)) begin
                    state_d = S_ADDIEX;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEMADR: begin
                if (opcode_q == OP_W'(OPC_LW)) begin
                    state_d = S_MEMRD;
                end else if (opcode_q == OP_W'(OPC_SW)) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (expired) begin
                    state_d = S_FETCH;
                    timeout = 1'b1;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (expired) begin
                    state_d = S_FETCH;
                    timeout = 1'b1;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        mem_err     = timeout;
        state_o     = state_q;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // Only commit the fetched instruction and PC+4 once memory
                // has actually delivered it.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
`endif
            S_TRAP: illegal_op = 1'b1;
            default: ;
        endcase
        // Reset forces every strobe low combinationally, independent of clk.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            illegal_op  = 1'b0;
            mem_err     = 1'b0;
            state_o     = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control (MEM_TIMEOUT = 4). A reference
// model tracks each instruction as a class plus a step index into its state
// sequence and predicts state_o and every control output each cycle.
// Honours MULTICYCLE_CONTROL_JUMP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int OP_W = 6;
    localparam int TMO  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [OP_W-1:0] Opcode = '0;
    logic            mem_ready = 1'b0;
    logic            PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic            IRWrite, RegDst, RegWrite, ALUSrcA;
    logic [1:0]      ALUSrcB, ALUOp, PCSource;
    logic            illegal_op, mem_err;
    logic [3:0]      state_o;

    multicycle_control #(
        .OP_W        (OP_W),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (Opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .mem_err     (mem_err),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Instruction classes: 0 R, 1 LW, 2 SW, 3 BEQ, 4 J, 5 ADDI, 6 TRAP.
    // Each row lists the states visited from FETCH onwards.
    int seq[7][5] = '{'{0, 1, 6, 7, 0}, '{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0},
                      '{0, 1, 8, 0, 0}, '{0, 1, 9, 0, 0}, '{0, 1, 10, 11, 0},
                      '{0, 1, 12, 0, 0}};
    int seq_len[7] = '{4, 5, 4, 3, 3, 4, 3};

    int m_cls  = 0;
    int m_idx  = 0;
    int m_wait = 0;

    int c_fetch, c_memread, c_memwrite, c_regwrite, c_rwdst, c_ill, c_err, c_pcw;

    function automatic int classify(input logic [OP_W-1:0] op);
        case (op)
            6'd0:  return 0;
            6'd35: return 1;
            6'd43: return 2;
            6'd4:  return 3;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            6'd2:  return 4;
`endif
            6'd8:  return 5;
            default: return 6;
        endcase
    endfunction

    // Packed as {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
    //            RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op,mem_err}
    function automatic logic [17:0] exp_ctrl(input int st, input logic rdy, input logic err);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2, 10: begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin pcw = 1; psrc = 2'b10; end
            11: rw = 1;
            12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, asb, aop, psrc, ill, err};
    endfunction

    wire [17:0] dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_err};

    task automatic clr_counts();
        c_fetch = 0; c_memread = 0; c_memwrite = 0; c_regwrite = 0;
        c_rwdst = 0; c_ill = 0; c_err = 0; c_pcw = 0;
    endtask

    // One clock cycle: drive at the falling edge, compare, then advance model.
    task automatic cyc(input logic [OP_W-1:0] op, input logic rdy);
        int   st;
        logic waiting;
        logic err;
        @(negedge clk);
        rst_n = 1'b1;
        Opcode = op;
        mem_ready = rdy;
        #1;
        st      = seq[m_cls][m_idx];
        waiting = (st == 0 || st == 3 || st == 5) && !rdy;
        err     = waiting && (m_wait + 1 == TMO);
        check("state", 32'(state_o), 32'(st));
        check("ctrl", 32'(dut_vec), 32'(exp_ctrl(st, rdy, err)));
        if (state_o == 4'd0) c_fetch++;
        if (MemRead)  c_memread++;
        if (MemWrite) c_memwrite++;
        if (RegWrite) c_regwrite++;
        if (RegWrite && RegDst) c_rwdst++;
        if (illegal_op) c_ill++;
        if (mem_err) c_err++;
        if (PCWrite) c_pcw++;
        if (waiting) begin
            if (err) begin
                m_idx  = 0;
                m_wait = 0;
            end else begin
                m_wait++;
            end
        end else begin
            m_wait = 0;
            if (m_idx == 1) m_cls = classify(op);
            m_idx++;
            if (m_idx == seq_len[m_cls]) m_idx = 0;
        end
    endtask

    // Runs len cycles with constant opcode; mem_ready low for cycles s0..s0+ns-1.
    task automatic run_instr(input logic [OP_W-1:0] op, input int len, input int s0, input int ns);
        clr_counts();
        for (int k = 1; k <= len; k++) begin
            cyc(op, !(k >= s0 && k < s0 + ns));
        end
    endtask

    logic [OP_W-1:0] ops[6] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};

    initial begin
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ctrl", 32'(dut_vec), 32'd0);
        repeat (2) @(posedge clk);

        // R-type, no waits: 0,1,6,7 then FETCH; one RegWrite with RegDst
        run_instr(6'd0, 4, 0, 0);
        check("r_fetch", 32'(c_fetch), 32'd1);
        check("r_rwdst", 32'(c_rwdst), 32'd1);
        check("r_regwr", 32'(c_regwrite), 32'd1);

        // LW with two MEMRD wait cycles: 7 cycles, MemRead in FETCH + 3 in MEMRD
        run_instr(6'd35, 7, 4, 2);
        check("lw_memrd", 32'(c_memread), 32'd4);
        check("lw_regwr", 32'(c_regwrite), 32'd1);
        check("lw_fetch", 32'(c_fetch), 32'd1);

        // Unsupported opcode traps once
        run_instr(6'd63, 3, 0, 0);
        check("trap_ill", 32'(c_ill), 32'd1);

        // Fetch timeout: four waits, one mem_err, never PCWrite, stays in FETCH
        run_instr(6'd0, 4, 1, 4);
        check("fto_err", 32'(c_err), 32'd1);
        check("fto_pcw", 32'(c_pcw), 32'd0);
        check("fto_fetch", 32'(c_fetch), 32'd4);

        // Timeout inside MEMRD: back to FETCH with no register write
        run_instr(6'd35, 7, 4, 4);
        check("rto_err", 32'(c_err), 32'd1);
        check("rto_regwr", 32'(c_regwrite), 32'd0);

        // Ready arriving on the TMO-th wait cycle counts as success
        run_instr(6'd35, 8, 4, 3);
        check("edge_err", 32'(c_err), 32'd0);
        check("edge_regwr", 32'(c_regwrite), 32'd1);

        // Opcode 2: jump when enabled, trap otherwise
        run_instr(6'd2, 3, 0, 0);
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        check("j_pcw", 32'(c_pcw), 32'd2);
        check("j_ill", 32'(c_ill), 32'd0);
`else
        check("j_pcw", 32'(c_pcw), 32'd1);
        check("j_ill", 32'(c_ill), 32'd1);
`endif

        run_instr(6'd4, 3, 0, 0);
        run_instr(6'd8, 4, 0, 0);
        check("addi_regwr", 32'(c_regwrite), 32'd1);
        run_instr(6'd43, 4, 0, 0);
        check("sw_memwr", 32'(c_memwrite), 32'd1);

        // Reset in the middle of a stalled MEMWR
        cyc(6'd43, 1'b1);
        cyc(6'd43, 1'b1);
        cyc(6'd43, 1'b1);
        cyc(6'd43, 1'b0);
        check("mw_before", 32'(MemWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mw_rst", 32'(MemWrite), 32'd0);
        check("mw_rst_state", 32'(state_o), 32'd0);
        check("mw_rst_ctrl", 32'(dut_vec), 32'd0);
        m_idx  = 0;
        m_wait = 0;
        @(posedge clk);
        #1;
        check("rst_hold", 32'(dut_vec), 32'd0);

        // Randomised traffic with varying memory readiness
        for (int seg = 0; seg < 3; seg++) begin
            for (int i = 0; i < 200; i++) begin
                int r;
                logic [OP_W-1:0] op;
                r  = $urandom_range(0, 6);
                op = (r == 6) ? OP_W'($urandom) : ops[r];
                cyc(op, $urandom_range(0, 7) < (seg == 0 ? 7 : (seg == 1 ? 5 : 2)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
